// File: rtl/mc_fifo_pkg.sv
// Shared widths and helpers for the multi-channel FIFO.
package mc_fifo_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_DEPTH_BITS = 3;
    localparam int DEF_CH_BITS    = 2;
    localparam int DEF_CNT_BITS   = DEF_DEPTH_BITS + 1;

    // Occupancy needs one extra bit so a completely full channel is representable.
    function automatic int cnt_bits(input int depth_bits);
        return depth_bits + 1;
    endfunction

    function automatic int cnt_lsb(input int ch, input int depth_bits);
        return ch * cnt_bits(depth_bits);
    endfunction

endpackage

// File: rtl/mc_fifo_mem.sv
// Flat storage shared by all channels: one synchronous write port, one asynchronous read port.
module mc_fifo_mem #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem_q [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational read gives first-word fall-through at the FIFO output.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mc_fifo.sv
// Multi-channel FWFT FIFO: NUM_CH queues share one array, steered by wr_ch / rd_ch.
// Define MC_FIFO_ERR_EN to add sticky per-channel overflow/underflow outputs (ovf, udf).
module mc_fifo
    import mc_fifo_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH_BITS = DEF_DEPTH_BITS,
    parameter int DEPTH      = 1 << DEPTH_BITS,
    parameter int CH_BITS    = DEF_CH_BITS,
    parameter int NUM_CH     = 1 << CH_BITS,
    parameter int AF_LEVEL   = DEPTH - 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr,
    input  logic [CH_BITS-1:0]                 wr_ch,
    input  logic [WIDTH-1:0]                   din,
    input  logic                               rd,
    input  logic [CH_BITS-1:0]                 rd_ch,
    output logic [WIDTH-1:0]                   dout,
    output logic                               dout_vld,
    input  logic [NUM_CH-1:0]                  flush,
    output logic [NUM_CH-1:0]                  full,
    output logic [NUM_CH-1:0]                  empty,
    output logic [NUM_CH-1:0]                  afull,
    output logic [NUM_CH*(DEPTH_BITS+1)-1:0]   count
`ifdef MC_FIFO_ERR_EN
    ,
    output logic [NUM_CH-1:0]                  ovf,
    output logic [NUM_CH-1:0]                  udf
`endif
);

    localparam int CW = cnt_bits(DEPTH_BITS);
    localparam int AW = CH_BITS + DEPTH_BITS;

    typedef logic [DEPTH_BITS-1:0] ptr_t;
    typedef logic [CW-1:0]         cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t CNT_AF   = cnt_t'(AF_LEVEL);

    logic [NUM_CH*DEPTH_BITS-1:0] rptr_flat;
    logic [NUM_CH*DEPTH_BITS-1:0] wptr_flat;

    logic          same_ch_pop;
    logic          wr_acc;
    logic          rd_acc;
    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    // A full channel still takes a write when the same channel is popped this cycle.
    assign same_ch_pop = rd & (rd_ch == wr_ch) & ~empty[rd_ch];
    assign wr_acc      = wr & (~full[wr_ch] | same_ch_pop) & ~flush[wr_ch];
    assign rd_acc      = rd & ~empty[rd_ch] & ~flush[rd_ch];

    assign wr_ptr = wptr_flat[wr_ch*DEPTH_BITS +: DEPTH_BITS];
    assign rd_ptr = rptr_flat[rd_ch*DEPTH_BITS +: DEPTH_BITS];
    assign waddr  = {wr_ch, wr_ptr};
    assign raddr  = {rd_ch, rd_ptr};

    mc_fifo_mem #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (waddr),
        .wdata (din),
        .raddr (raddr),
        .rdata (dout)
    );

    assign dout_vld = ~empty[rd_ch];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : ch_g
            ptr_t rptr_q;
            ptr_t rptr_d;
            ptr_t wptr_q;
            ptr_t wptr_d;
            cnt_t cnt_q;
            cnt_t cnt_d;
            logic wr_hit;
            logic rd_hit;

            assign wr_hit = wr_acc & (wr_ch == CH_BITS'(gi));
            assign rd_hit = rd_acc & (rd_ch == CH_BITS'(gi));

            always_comb begin
                rptr_d = rptr_q;
                wptr_d = wptr_q;
                cnt_d  = cnt_q;
                if (flush[gi]) begin
                    rptr_d = '0;
                    wptr_d = '0;
                    cnt_d  = '0;
                end else begin
                    if (wr_hit) begin
                        wptr_d = wptr_q + ptr_t'(1);
                    end
                    if (rd_hit) begin
                        rptr_d = rptr_q + ptr_t'(1);
                    end
                    if (wr_hit && !rd_hit) begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end else if (rd_hit && !wr_hit) begin
                        cnt_d = cnt_q - cnt_t'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rptr_q <= '0;
                    wptr_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    rptr_q <= rptr_d;
                    wptr_q <= wptr_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign full[gi]  = (cnt_q == CNT_FULL);
            assign empty[gi] = (cnt_q == '0);
            assign afull[gi] = (cnt_q >= CNT_AF);

            assign count[gi*CW +: CW]                 = cnt_q;
            assign rptr_flat[gi*DEPTH_BITS +: DEPTH_BITS] = rptr_q;
            assign wptr_flat[gi*DEPTH_BITS +: DEPTH_BITS] = wptr_q;

`ifdef MC_FIFO_ERR_EN
            logic ovf_q;
            logic ovf_d;
            logic udf_q;
            logic udf_d;
            logic ovf_set;
            logic udf_set;

            // Accesses blocked by a flush are not errors; only full/empty rejections are.
            assign ovf_set = wr & (wr_ch == CH_BITS'(gi)) & ~flush[gi] & ~wr_hit;
            assign udf_set = rd & (rd_ch == CH_BITS'(gi)) & ~flush[gi] & empty[gi];

            always_comb begin
                ovf_d = ovf_q | ovf_set;
                udf_d = udf_q | udf_set;
                if (flush[gi]) begin
                    ovf_d = 1'b0;
                    udf_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                    udf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                    udf_q <= udf_d;
                end
            end

            assign ovf[gi] = ovf_q;
            assign udf[gi] = udf_q;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_mc_fifo.sv
// Self-checking bench for mc_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_mc_fifo;

    logic        clk;
    logic        rst_n;
    logic        wr;
    logic [1:0]  wr_ch;
    logic [15:0] din;
    logic        rd;
    logic [1:0]  rd_ch;
    logic [15:0] dout;
    logic        dout_vld;
    logic [3:0]  flush;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic [3:0]  afull;
    logic [15:0] count;
`ifdef MC_FIFO_ERR_EN
    logic [3:0]  ovf;
    logic [3:0]  udf;
`endif

    int tests_run;
    int tests_failed;

    // Reference model: one queue per channel plus sticky error bits.
    logic [15:0] mq [4][$];
    logic [3:0]  movf;
    logic [3:0]  mudf;

    mc_fifo #(
        .WIDTH      (16),
        .DEPTH_BITS (3),
        .CH_BITS    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wr),
        .wr_ch    (wr_ch),
        .din      (din),
        .rd       (rd),
        .rd_ch    (rd_ch),
        .dout     (dout),
        .dout_vld (dout_vld),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .afull    (afull),
        .count    (count)
`ifdef MC_FIFO_ERR_EN
        ,
        .ovf      (ovf),
        .udf      (udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_count();
        logic [15:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) r[c*4 +: 4] = 4'(mq[c].size());
        return r;
    endfunction

    function automatic logic [3:0] exp_empty();
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = (mq[c].size() == 0);
        return r;
    endfunction

    function automatic logic [3:0] exp_full();
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = (mq[c].size() == 8);
        return r;
    endfunction

    function automatic logic [3:0] exp_afull();
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = (mq[c].size() >= 6);
        return r;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < 4; c++) mq[c].delete();
        movf = '0;
        mudf = '0;
    endfunction

    function automatic void model_apply(input bit w, input logic [1:0] wc, input logic [15:0] d,
                                        input bit r, input logic [1:0] rc, input logic [3:0] fl);
        bit wa;
        bit ra;
        int ws;
        int rs;
        ws = mq[wc].size();
        rs = mq[rc].size();
        ra = r && !fl[rc] && rs > 0;
        wa = w && !fl[wc] && (ws < 8 || (r && rc == wc && rs > 0));
        if (w && !fl[wc] && !wa) movf[wc] = 1'b1;
        if (r && !fl[rc] && rs == 0) mudf[rc] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (fl[c]) begin
                mq[c].delete();
                movf[c] = 1'b0;
                mudf[c] = 1'b0;
            end
        end
        if (ra) void'(mq[rc].pop_front());
        if (wa) mq[wc].push_back(d);
    endfunction

    // One clock of traffic; returns at the following falling edge with strobes idle.
    task automatic step(input bit w, input logic [1:0] wc, input logic [15:0] d,
                        input bit r, input logic [1:0] rc, input logic [3:0] fl);
        wr = w; wr_ch = wc; din = d; rd = r; rd_ch = rc; flush = fl;
        @(posedge clk);
        model_apply(w, wc, d, r, rc, fl);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; flush = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr = 1'b0; wr_ch = '0; din = '0; rd = 1'b0; rd_ch = '0; flush = '0;
        model_clear();
        @(negedge clk);
        tests_run++;
        if (count !== 16'h0) begin
            tests_failed++; $display("FAIL reset_count got=%h exp=%h", count, 16'h0);
        end
        tests_run++;
        if (empty !== 4'hF || full !== 4'h0 || afull !== 4'h0) begin
            tests_failed++; $display("FAIL reset_flags got e=%b f=%b af=%b exp e=1111 f=0000 af=0000", empty, full, afull);
        end
        tests_run++;
        if (dout_vld !== 1'b0) begin
            tests_failed++; $display("FAIL reset_vld got=%b exp=0", dout_vld);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        logic [15:0] exp_d;
        step(1, 2'd1, 16'h1111, 0, 2'd0, 4'h0);
        step(1, 2'd1, 16'h2222, 0, 2'd0, 4'h0);
        step(1, 2'd1, 16'h3333, 0, 2'd0, 4'h0);
        tests_run++;
        if (count[7:4] !== 4'd3 || empty !== 4'b1101) begin
            tests_failed++; $display("FAIL basic_fill got cnt1=%0d empty=%b exp cnt1=3 empty=1101", count[7:4], empty);
        end
        for (int i = 0; i < 3; i++) begin
            exp_d = 16'h1111 * 16'(i + 1);
            rd_ch = 2'd1;
            #1;
            tests_run++;
            if (dout_vld !== 1'b1 || dout !== exp_d) begin
                tests_failed++; $display("FAIL basic_pop%0d got vld=%b dout=%h exp vld=1 dout=%h", i, dout_vld, dout, exp_d);
            end
            step(0, 2'd0, 16'h0, 1, 2'd1, 4'h0);
        end
        tests_run++;
        if (empty[1] !== 1'b1 || dout_vld !== 1'b0) begin
            tests_failed++; $display("FAIL basic_drain got empty1=%b vld=%b exp 1 0", empty[1], dout_vld);
        end
        $display("[TB] basic ch1 write/pop checked");
    endtask

    task automatic test_full_wrap();
        logic [15:0] exp_d;
        for (int i = 0; i < 8; i++) begin
            step(1, 2'd2, 16'hA000 + 16'(i), 0, 2'd0, 4'h0);
            tests_run++;
            if (afull[2] !== (i >= 5) || full[2] !== (i == 7)) begin
                tests_failed++; $display("FAIL full_fill%0d got af=%b f=%b exp af=%b f=%b", i, afull[2], full[2], (i >= 5), (i == 7));
            end
        end
        step(1, 2'd2, 16'hBEEF, 0, 2'd0, 4'h0);
        tests_run++;
        if (count[11:8] !== 4'd8 || full[2] !== 1'b1) begin
            tests_failed++; $display("FAIL full_drop got cnt2=%0d full2=%b exp 8 1", count[11:8], full[2]);
        end
`ifdef MC_FIFO_ERR_EN
        tests_run++;
        if (ovf !== 4'b0100) begin
            tests_failed++; $display("FAIL full_ovf got=%b exp=0100", ovf);
        end
`endif
        rd_ch = 2'd2;
        #1;
        tests_run++;
        if (dout !== 16'hA000) begin
            tests_failed++; $display("FAIL full_rw_head got=%h exp=a000", dout);
        end
        step(1, 2'd2, 16'hC0DE, 1, 2'd2, 4'h0);
        tests_run++;
        if (count[11:8] !== 4'd8) begin
            tests_failed++; $display("FAIL full_rw_count got=%0d exp=8", count[11:8]);
        end
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 7) ? (16'hA001 + 16'(i)) : 16'hC0DE;
            rd_ch = 2'd2;
            #1;
            tests_run++;
            if (dout_vld !== 1'b1 || dout !== exp_d) begin
                tests_failed++; $display("FAIL full_pop%0d got vld=%b dout=%h exp vld=1 dout=%h", i, dout_vld, dout, exp_d);
            end
            step(0, 2'd0, 16'h0, 1, 2'd2, 4'h0);
        end
        tests_run++;
        if (empty !== 4'hF) begin
            tests_failed++; $display("FAIL full_drained got=%b exp=1111", empty);
        end
        $display("[TB] full/afull/drop/wrap on ch2 checked");
    endtask

    task automatic test_empty_rw();
        rd_ch = 2'd0;
        step(1, 2'd0, 16'h5555, 1, 2'd0, 4'h0);
        tests_run++;
        if (count[3:0] !== 4'd1) begin
            tests_failed++; $display("FAIL empty_rw_count got=%0d exp=1", count[3:0]);
        end
        tests_run++;
        if (dout_vld !== 1'b1 || dout !== 16'h5555) begin
            tests_failed++; $display("FAIL empty_rw_dout got vld=%b dout=%h exp vld=1 dout=5555", dout_vld, dout);
        end
`ifdef MC_FIFO_ERR_EN
        tests_run++;
        if (udf[0] !== 1'b1) begin
            tests_failed++; $display("FAIL empty_rw_udf got=%b exp=1", udf[0]);
        end
`endif
        $display("[TB] empty-channel read+write on ch0 checked");
    endtask

    task automatic test_flush();
        step(1, 2'd0, 16'h0A01, 0, 2'd0, 4'h0);
        step(1, 2'd0, 16'h0A02, 0, 2'd0, 4'h0);
        step(1, 2'd3, 16'h3301, 0, 2'd0, 4'h0);
        step(1, 2'd3, 16'h3302, 0, 2'd0, 4'h0);
        tests_run++;
        if (count[3:0] !== 4'd3 || count[15:12] !== 4'd2) begin
            tests_failed++; $display("FAIL flush_pre got c0=%0d c3=%0d exp 3 2", count[3:0], count[15:12]);
        end
        step(1, 2'd0, 16'hDEAD, 0, 2'd0, 4'b0001);
        tests_run++;
        if (count[3:0] !== 4'd0 || empty[0] !== 1'b1 || dout_vld !== 1'b0) begin
            tests_failed++; $display("FAIL flush_ch0 got c0=%0d e0=%b vld=%b exp 0 1 0", count[3:0], empty[0], dout_vld);
        end
        tests_run++;
        if (count[15:12] !== 4'd2) begin
            tests_failed++; $display("FAIL flush_ch3_count got=%0d exp=2", count[15:12]);
        end
`ifdef MC_FIFO_ERR_EN
        tests_run++;
        if (udf[0] !== 1'b0 || ovf[2] !== 1'b1) begin
            tests_failed++; $display("FAIL flush_err got udf0=%b ovf2=%b exp 0 1", udf[0], ovf[2]);
        end
`endif
        for (int i = 0; i < 2; i++) begin
            rd_ch = 2'd3;
            #1;
            tests_run++;
            if (dout !== 16'h3301 + 16'(i)) begin
                tests_failed++; $display("FAIL flush_ch3_pop%0d got=%h exp=%h", i, dout, 16'h3301 + 16'(i));
            end
            step(0, 2'd0, 16'h0, 1, 2'd3, 4'h0);
        end
        $display("[TB] flush of ch0 with ch3 intact checked");
    endtask

    task automatic test_random();
        bit          w;
        bit          r;
        logic [1:0]  wc;
        logic [1:0]  rc;
        logic [15:0] d;
        logic [3:0]  fl;
        for (int n = 0; n < 400; n++) begin
            w  = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 9) < 4);
            wc = 2'($urandom_range(0, 3));
            rc = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : wc;
            d  = 16'($urandom);
            fl = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'h0;
            rd_ch = rc;
            #1;
            tests_run++;
            if (dout_vld !== (mq[rc].size() > 0)) begin
                tests_failed++; $display("FAIL rnd_vld n=%0d ch=%0d got=%b exp=%b", n, rc, dout_vld, (mq[rc].size() > 0));
            end
            if (mq[rc].size() > 0) begin
                tests_run++;
                if (dout !== mq[rc][0]) begin
                    tests_failed++; $display("FAIL rnd_dout n=%0d ch=%0d got=%h exp=%h", n, rc, dout, mq[rc][0]);
                end
            end
            step(w, wc, d, r, rc, fl);
            tests_run++;
            if (count !== exp_count()) begin
                tests_failed++; $display("FAIL rnd_count n=%0d got=%h exp=%h", n, count, exp_count());
            end
            tests_run++;
            if (empty !== exp_empty() || full !== exp_full() || afull !== exp_afull()) begin
                tests_failed++; $display("FAIL rnd_flags n=%0d got e=%b f=%b af=%b exp e=%b f=%b af=%b",
                                         n, empty, full, afull, exp_empty(), exp_full(), exp_afull());
            end
`ifdef MC_FIFO_ERR_EN
            tests_run++;
            if (ovf !== movf || udf !== mudf) begin
                tests_failed++; $display("FAIL rnd_err n=%0d got ovf=%b udf=%b exp ovf=%b udf=%b", n, ovf, udf, movf, mudf);
            end
`endif
        end
        $display("[TB] randomized traffic checked (400 cycles)");
    endtask

    task automatic test_async_reset();
        step(1, 2'd1, 16'h7777, 0, 2'd1, 4'h0);
        step(1, 2'd2, 16'h8888, 0, 2'd1, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (count !== 16'h0 || empty !== 4'hF) begin
            tests_failed++; $display("FAIL async_reset got cnt=%h empty=%b exp cnt=0000 empty=1111", count, empty);
        end
        tests_run++;
        if (dout_vld !== 1'b0 || full !== 4'h0 || afull !== 4'h0) begin
            tests_failed++; $display("FAIL async_reset_flags got vld=%b f=%b af=%b exp 0 0000 0000", dout_vld, full, afull);
        end
`ifdef MC_FIFO_ERR_EN
        tests_run++;
        if (ovf !== 4'h0 || udf !== 4'h0) begin
            tests_failed++; $display("FAIL async_reset_err got ovf=%b udf=%b exp 0 0", ovf, udf);
        end
`endif
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] asynchronous reset mid-stream checked");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_full_wrap();
        test_empty_rw();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
